enc_ctrl: RTL and testbench
===========================

// Module: enc_ctrl
// PURPOSE
//  Sequences the TX convolutional encoder (K=7, g0=133o/g1=171o) for one 802.11a DATA field.
//  Serialises bytes LSB-first, drives encoder enable/data and appends 6 zero tail bits.
//  Applies rate-dependent puncturing (1/2, 2/3, 3/4) to the encoder's A/B outputs.
//  Emits a registered coded pair plus keep-mask to the interleaver-side bit packer.
// PARAMETERS
//  DW        8   input byte width
//  TAIL_LEN  6   zero tail bits appended after the last data bit
// PORTS
//  iClk       in   1   clock (slow domain, same as encoder)
//  iRst       in   1   reset: synchronous, active-high
//  iStart     in   1   frame start; sampled in IDLE only
//  iRate      in   2   00=1/2, 01=2/3, 10=3/4, 11=reserved (treated as 1/2); latched on iStart
//  iAbort     in   1   abandon current frame
//  iByte      in   DW  data byte
//  iByteVld   in   1   byte valid
//  iLast      in   1   qualifies iByte as final byte of frame
//  oByteRdy   out  1   byte accepted when iByteVld & oByteRdy
//  oEncEN     out  1   encoder shift enable
//  oEncData   out  1   encoder serial input
//  oEncRst    out  1   one-cycle encoder clear (after abort only)
//  iEncA      in   1   encoder output A (combinational from oEncData)
//  iEncB      in   1   encoder output B
//  oCode      out  2   [1]=A, [0]=B, registered
//  oCodeMask  out  2   keep bits, [1]=A, [0]=B; 00 when no output
//  oCodeVld   out  1   oCode/oCodeMask valid
//  oBusy      out  1   state != IDLE
//  oDone      out  1   one-cycle pulse after last tail pair is presented
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; buffer empty; counters 0; rate=1/2.
//  FSM IDLE -> DATA on iStart (rate latched, puncture phase=0, bitcnt=0).
//    DATA -> TAIL after bit 7 of the byte flagged iLast; TAIL -> FLUSH after TAIL_LEN steps;
//    FLUSH -> IDLE after one cycle, pulsing oDone. iStart outside IDLE is ignored.
//  Byte buffer: 8-bit shift reg + valid flag. oByteRdy = DATA & !lastTaken &
//    (!bufVld | (bitcnt==7 & step)). Back-to-back bytes stream at 8 cycles/byte, no bubble.
//  Step (oEncEN=1): DATA & bufVld -> oEncData=buf[bitcnt]; TAIL -> oEncData=0.
//  Underrun (DATA, buffer empty, no byte): oEncEN=0, no step, phase held, oCodeVld=0.
//  Output latency 1: cycle after a step, oCode={iEncA,iEncB}, oCodeVld=1, mask per phase.
//  Puncture phase advances once per step, continuous across data and tail:
//    1/2: mod 1, mask 11.  2/3: mod 2, masks 11,10.  3/4: mod 3, masks 11,10,01.
//  iAbort (any non-IDLE state): next cycle IDLE, oEncRst=1 for one cycle, buffer dropped,
//    oCodeVld=0, no oDone. iAbort wins over simultaneous byte acceptance or step.
//  iRst mid-frame: immediate reset state; encoder clearing is the top level's job
//    (encoder shares iRst).
//  Tail returns encoder to state 0, so no clear between normal frames.
// STRUCTURE
//  Package enc_pkg: rate codes, FSM state encoding, TAIL_LEN, puncture mask table.
//  Sub-module enc_punct: phase counter + mask lookup (iRate, iStep, iClr -> mask).
//  Encoder instance lives at the TX top, not inside this block.
// TESTING
//  1/2, single byte 0x01, iLast=1 -> first pair A=1,B=1 mask 11; 14 valid cycles
//    (28 bits); oDone 1 cycle after last valid.
//  3/4, byte 0x01 -> 14 valid cycles, masks 11,10,01 x4 then 11,10 -> 19 kept bits.
//  2/3, two back-to-back bytes 0xA5,0x3C -> 22 consecutive valid cycles, no gaps;
//    oByteRdy high in the last bit cycle of 0xA5; 33 kept bits.
//  Underrun: drop iByteVld for 5 cycles between bytes -> oEncEN=0 and oCodeVld=0 for 5 cycles;
//    mask sequence resumes without phase slip.
//  iAbort at 3rd tail step -> IDLE next cycle, oEncRst pulse, no oDone;
//    new 1/2 frame with 0x00 gives all-zero pairs.
//  iRst in DATA -> all outputs 0 next cycle; iStart during DATA ignored (rate unchanged).

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and tables for the TX convolutional encoder controller:
// rate codes, controller states, tail length and the puncturing mask table.
package enc_pkg;

    localparam int DW       = 8;
    localparam int TAIL_LEN = 6;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'b00,
        RATE_2_3  = 2'b01,
        RATE_3_4  = 2'b10,
        RATE_RSVD = 2'b11
    } rateT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DATA  = 2'b01,
        ST_TAIL  = 2'b10,
        ST_FLUSH = 2'b11
    } stateT;

    // The reserved code falls back to the unpunctured 1/2 rate.
    function automatic rateT normRate(input logic [1:0] code);
        case (code)
            2'b01:   normRate = RATE_2_3;
            2'b10:   normRate = RATE_3_4;
            default: normRate = RATE_1_2;
        endcase
    endfunction

    function automatic logic [1:0] phaseLast(input rateT rate);
        case (rate)
            RATE_2_3: phaseLast = 2'd1;
            RATE_3_4: phaseLast = 2'd2;
            default:  phaseLast = 2'd0;
        endcase
    endfunction

    // Keep mask {A,B} per puncture phase.
    function automatic logic [1:0] punctMask(input rateT rate, input logic [1:0] phase);
        case (rate)
            RATE_2_3: punctMask = (phase == 2'd0) ? 2'b11 : 2'b10;
            RATE_3_4: begin
                case (phase)
                    2'd0:    punctMask = 2'b11;
                    2'd1:    punctMask = 2'b10;
                    default: punctMask = 2'b01;
                endcase
            end
            default:  punctMask = 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/enc_punct.sv
// Puncture phase counter: advances once per encoder step and looks up the
// keep mask for the current phase of the latched rate.
module enc_punct
    import enc_pkg::*;
(
    input  logic       iClk,
    input  logic       iRst,
    input  rateT       iRate,
    input  logic       iStep,
    input  logic       iClr,
    output logic [1:0] oMask
);

    logic [1:0] phase;

    always_ff @(posedge iClk) begin
        if (iRst || iClr) begin
            phase <= 2'd0;
        end else if (iStep) begin
            phase <= (phase == phaseLast(iRate)) ? 2'd0 : phase + 2'd1;
        end
    end

    assign oMask = punctMask(iRate, phase);

endmodule

// File: rtl/enc_ctrl.sv
// Sequences the K=7 convolutional encoder for one DATA field: serialises bytes
// LSB-first, appends the zero tail and emits punctured coded pairs.
module enc_ctrl
    import enc_pkg::*;
#(
    parameter int DW       = enc_pkg::DW,
    parameter int TAIL_LEN = enc_pkg::TAIL_LEN
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iStart,
    input  logic [1:0]    iRate,
    input  logic          iAbort,
    input  logic [DW-1:0] iByte,
    input  logic          iByteVld,
    input  logic          iLast,
    output logic          oByteRdy,
    output logic          oEncEN,
    output logic          oEncData,
    output logic          oEncRst,
    input  logic          iEncA,
    input  logic          iEncB,
    output logic [1:0]    oCode,
    output logic [1:0]    oCodeMask,
    output logic          oCodeVld,
    output logic          oBusy,
    output logic          oDone
);

    localparam int BW = $clog2(DW);
    localparam int TW = $clog2(TAIL_LEN + 1);

    stateT         state;
    rateT          rate;
    logic [DW-1:0] byteBuf;
    logic          bufVld;
    logic          bufLast;
    logic          lastTaken;
    logic [BW-1:0] bitCnt;
    logic [TW-1:0] tailCnt;

    logic       stepData;
    logic       step;
    logic       bitLast;
    logic       accept;
    logic       punctClr;
    logic [1:0] mask;

    // Byte handshake: a byte transfers on any cycle where iByteVld and oByteRdy
    // are both high; iByte/iLast must hold while iByteVld waits for oByteRdy.
    assign stepData = (state == ST_DATA) && bufVld;
    assign step     = !iAbort && (stepData || (state == ST_TAIL));
    assign bitLast  = (bitCnt == BW'(DW - 1));
    assign oByteRdy = (state == ST_DATA) && !lastTaken && (!bufVld || (bitLast && step));
    assign accept   = oByteRdy && iByteVld && !iAbort;
    assign punctClr = (state == ST_IDLE) && iStart;

    assign oEncEN   = step;
    assign oEncData = stepData && byteBuf[bitCnt];
    assign oBusy    = (state != ST_IDLE);

    enc_punct uPunct (
        .iClk  (iClk),
        .iRst  (iRst),
        .iRate (rate),
        .iStep (step),
        .iClr  (punctClr),
        .oMask (mask)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= ST_IDLE;
            rate      <= RATE_1_2;
            byteBuf   <= '0;
            bufVld    <= 1'b0;
            bufLast   <= 1'b0;
            lastTaken <= 1'b0;
            bitCnt    <= '0;
            tailCnt   <= '0;
            oEncRst   <= 1'b0;
            oCode     <= 2'b00;
            oCodeMask <= 2'b00;
            oCodeVld  <= 1'b0;
            oDone     <= 1'b0;
        end else begin
            oEncRst   <= 1'b0;
            oDone     <= 1'b0;
            oCodeVld  <= step;
            oCodeMask <= step ? mask : 2'b00;
            oCode     <= step ? {iEncA, iEncB} : 2'b00;

            if ((state != ST_IDLE) && iAbort) begin
                state     <= ST_IDLE;
                oEncRst   <= 1'b1;
                bufVld    <= 1'b0;
                bufLast   <= 1'b0;
                lastTaken <= 1'b0;
                bitCnt    <= '0;
                tailCnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (iStart) begin
                            state     <= ST_DATA;
                            rate      <= normRate(iRate);
                            bufVld    <= 1'b0;
                            bufLast   <= 1'b0;
                            lastTaken <= 1'b0;
                            bitCnt    <= '0;
                            tailCnt   <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (stepData) begin
                            bitCnt <= bitCnt + 1'b1;
                            if (bitLast) begin
                                bufVld <= 1'b0;
                                if (bufLast) begin
                                    state   <= ST_TAIL;
                                    tailCnt <= '0;
                                end
                            end
                        end
                        // A refill on the last bit overrides the empty flag above.
                        if (accept) begin
                            byteBuf   <= iByte;
                            bufVld    <= 1'b1;
                            bufLast   <= iLast;
                            lastTaken <= iLast;
                        end
                    end
                    ST_TAIL: begin
                        tailCnt <= tailCnt + 1'b1;
                        if (tailCnt == TW'(TAIL_LEN - 1)) begin
                            state <= ST_FLUSH;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        oDone <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enc_ctrl.sv
// Directed bench for enc_ctrl with a K=7 encoder stand-in and a scoreboard of
// expected {mask,A,B} words built from the byte list and generator polynomials.
module tb_enc_ctrl;

    localparam logic [6:0] G0 = 7'o133;
    localparam logic [6:0] G1 = 7'o171;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iStart;
    logic [1:0] iRate;
    logic       iAbort;
    logic [7:0] iByte;
    logic       iByteVld;
    logic       iLast;
    logic       oByteRdy;
    logic       oEncEN;
    logic       oEncData;
    logic       oEncRst;
    logic       iEncA;
    logic       iEncB;
    logic [1:0] oCode;
    logic [1:0] oCodeMask;
    logic       oCodeVld;
    logic       oBusy;
    logic       oDone;

    int total = 0;
    int bad   = 0;

    logic [3:0] expQ[$];
    logic [7:0] frameBytes [0:3];
    int         acceptStep [0:3];

    int         cycle = 0;
    int         stepCount, vldCount, keptBits, vldGap, encIdle;
    int         doneCount, doneDelay, lastVldCycle, nonZero;
    logic       vldStarted, doneSeen, firstStepSeen;
    logic [1:0] firstCode;

    enc_ctrl dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iStart    (iStart),
        .iRate     (iRate),
        .iAbort    (iAbort),
        .iByte     (iByte),
        .iByteVld  (iByteVld),
        .iLast     (iLast),
        .oByteRdy  (oByteRdy),
        .oEncEN    (oEncEN),
        .oEncData  (oEncData),
        .oEncRst   (oEncRst),
        .iEncA     (iEncA),
        .iEncB     (iEncB),
        .oCode     (oCode),
        .oCodeMask (oCodeMask),
        .oCodeVld  (oCodeVld),
        .oBusy     (oBusy),
        .oDone     (oDone)
    );

    always #5 iClk = ~iClk;

    // Encoder stand-in: encSr[5] is the previous bit, encSr[0] the oldest.
    logic [5:0] encSr;
    assign iEncA = ^({oEncData, encSr} & G0);
    assign iEncB = ^({oEncData, encSr} & G1);
    always @(posedge iClk) begin
        if (iRst || oEncRst) encSr <= 6'd0;
        else if (oEncEN)     encSr <= {oEncData, encSr[5:1]};
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic resetStats();
        stepCount = 0; vldCount = 0; keptBits = 0; vldGap = 0; encIdle = 0;
        doneCount = 0; doneDelay = 0; lastVldCycle = 0; nonZero = 0;
        vldStarted = 1'b0; doneSeen = 1'b0; firstStepSeen = 1'b0; firstCode = 2'b00;
        for (int i = 0; i < 4; i++) acceptStep[i] = -1;
    endtask

    // Expected pairs: bits LSB-first then six zeros, masks by step index.
    task automatic pushFrame(input logic [1:0] rate, input int nBytes, input int maxSteps);
        logic [6:0] win;
        logic [7:0] cur;
        logic       b;
        logic [1:0] m;
        int         nBits;
        win   = 7'd0;
        nBits = nBytes * 8 + 6;
        for (int i = 0; i < nBits && i < maxSteps; i++) begin
            if (i < nBytes * 8) begin
                cur = frameBytes[i / 8];
                b   = cur[i % 8];
            end else begin
                b = 1'b0;
            end
            win = {b, win[6:1]};
            case (rate)
                2'b01:   m = (i % 2 == 0) ? 2'b11 : 2'b10;
                2'b10:   m = (i % 3 == 0) ? 2'b11 : ((i % 3 == 1) ? 2'b10 : 2'b01);
                default: m = 2'b11;
            endcase
            expQ.push_back({m, ^(win & G0), ^(win & G1)});
        end
    endtask

    task automatic startFrame(input logic [1:0] rate);
        iStart = 1'b1;
        iRate  = rate;
        tick();
        iStart = 1'b0;
        iRate  = 2'b00;
    endtask

    task automatic feedBytes(input int nBytes, input int holdBefore1);
        int t;
        for (int b = 0; b < nBytes; b++) begin
            if (b == 1) repeat (holdBefore1) tick();
            iByte    = frameBytes[b];
            iByteVld = 1'b1;
            iLast    = (b == nBytes - 1);
            t = 0;
            while (!oByteRdy && t < 40) begin
                tick();
                t++;
            end
            if (t >= 40) checkVal("byteRdyTimeout", oByteRdy, 1);
            acceptStep[b] = stepCount;
            tick();
            iByteVld = 1'b0;
            iLast    = 1'b0;
        end
    endtask

    task automatic waitDone();
        int t;
        t = 0;
        while (!doneSeen && t < 80) begin
            tick();
            t++;
        end
        checkVal("doneSeen", doneSeen, 1);
        tick();
        tick();
    endtask

    // Monitor and scoreboard, sampled on the falling edge.
    initial begin : monitor
        forever begin
            @(negedge iClk);
            cycle++;
            if (firstStepSeen && oBusy && !oEncEN) encIdle++;
            if (oEncEN) begin
                stepCount++;
                firstStepSeen = 1'b1;
            end
            if (oCodeVld) begin
                if (expQ.size() == 0) begin
                    checkVal("extraPair", oCodeVld, 0);
                end else begin
                    checkVal("pair", {oCodeMask, oCode}, expQ.pop_front());
                end
                if (!vldStarted) firstCode = oCode;
                vldStarted = 1'b1;
                vldCount++;
                keptBits += oCodeMask[1] + oCodeMask[0];
                if (oCode != 2'b00) nonZero++;
                lastVldCycle = cycle;
            end else if (vldStarted && !doneSeen && !oDone) begin
                vldGap++;
            end
            if (oDone) begin
                doneCount++;
                doneSeen  = 1'b1;
                doneDelay = cycle - lastVldCycle;
            end
        end
    end

    initial begin : stimulus
        int t;
        iRst = 1'b1; iStart = 1'b0; iRate = 2'b00; iAbort = 1'b0;
        iByte = 8'h00; iByteVld = 1'b0; iLast = 1'b0;
        resetStats();
        repeat (3) tick();
        checkVal("rstOutputs", {oByteRdy, oEncEN, oEncData, oEncRst, oCode, oCodeMask,
                                oCodeVld, oBusy, oDone}, 0);
        iRst = 1'b0;
        tick();

        // 1/2, single byte 0x01
        resetStats();
        frameBytes[0] = 8'h01;
        pushFrame(2'b00, 1, 99);
        startFrame(2'b00);
        feedBytes(1, 0);
        waitDone();
        checkVal("t1FirstPair", firstCode, 2'b11);
        checkVal("t1Valid", vldCount, 14);
        checkVal("t1Kept", keptBits, 28);
        checkVal("t1DoneDelay", doneDelay, 1);
        checkVal("t1DoneCount", doneCount, 1);
        checkVal("t1Drained", expQ.size(), 0);
        checkVal("t1Idle", oBusy, 0);

        // 3/4, single byte 0x01
        resetStats();
        frameBytes[0] = 8'h01;
        pushFrame(2'b10, 1, 99);
        startFrame(2'b10);
        feedBytes(1, 0);
        waitDone();
        checkVal("t2Valid", vldCount, 14);
        checkVal("t2Kept", keptBits, 19);
        checkVal("t2Gap", vldGap, 0);
        checkVal("t2Drained", expQ.size(), 0);

        // 2/3, back-to-back 0xA5, 0x3C
        resetStats();
        frameBytes[0] = 8'hA5;
        frameBytes[1] = 8'h3C;
        pushFrame(2'b01, 2, 99);
        startFrame(2'b01);
        feedBytes(2, 0);
        waitDone();
        checkVal("t3Valid", vldCount, 22);
        checkVal("t3Gap", vldGap, 0);
        checkVal("t3RdyBit7", acceptStep[1], 7);
        checkVal("t3Kept", keptBits, 33);
        checkVal("t3Drained", expQ.size(), 0);

        // 3/4 with a 5-cycle underrun between bytes; idle count includes FLUSH
        resetStats();
        frameBytes[0] = 8'h5A;
        frameBytes[1] = 8'hC3;
        pushFrame(2'b10, 2, 99);
        startFrame(2'b10);
        feedBytes(2, 12);
        waitDone();
        checkVal("t4Gap", vldGap, 5);
        checkVal("t4EncIdle", encIdle, 6);
        checkVal("t4Valid", vldCount, 22);
        checkVal("t4Kept", keptBits, 30);
        checkVal("t4Drained", expQ.size(), 0);

        // Abort on the 3rd tail step (step index 10)
        resetStats();
        frameBytes[0] = 8'h96;
        pushFrame(2'b01, 1, 10);
        startFrame(2'b01);
        feedBytes(1, 0);
        t = 0;
        while (stepCount < 10 && t < 60) begin
            tick();
            t++;
        end
        if (t >= 60) checkVal("t5StepTimeout", stepCount, 10);
        iAbort = 1'b1;
        #1;
        checkVal("t5AbortNoStep", oEncEN, 0);
        tick();
        iAbort = 1'b0;
        checkVal("t5Idle", oBusy, 0);
        checkVal("t5EncRst", oEncRst, 1);
        checkVal("t5NoVld", oCodeVld, 0);
        tick();
        checkVal("t5EncRstPulse", oEncRst, 0);
        repeat (20) tick();
        checkVal("t5NoDone", doneCount, 0);
        checkVal("t5Valid", vldCount, 10);
        checkVal("t5Drained", expQ.size(), 0);

        // Fresh 1/2 frame of zeros after the abort
        resetStats();
        frameBytes[0] = 8'h00;
        pushFrame(2'b00, 1, 99);
        startFrame(2'b00);
        feedBytes(1, 0);
        waitDone();
        checkVal("t5bZero", nonZero, 0);
        checkVal("t5bValid", vldCount, 14);
        checkVal("t5bDrained", expQ.size(), 0);

        // iStart with a different rate during DATA is ignored
        resetStats();
        frameBytes[0] = 8'h3C;
        frameBytes[1] = 8'h81;
        pushFrame(2'b00, 2, 99);
        startFrame(2'b00);
        iStart = 1'b1;
        iRate  = 2'b10;
        tick();
        iStart = 1'b0;
        iRate  = 2'b00;
        feedBytes(2, 0);
        waitDone();
        checkVal("t6Valid", vldCount, 22);
        checkVal("t6Kept", keptBits, 44);
        checkVal("t6Drained", expQ.size(), 0);

        // Reset in the middle of DATA
        resetStats();
        frameBytes[0] = 8'hFF;
        pushFrame(2'b00, 1, 99);
        startFrame(2'b00);
        feedBytes(1, 0);
        t = 0;
        while (stepCount < 4 && t < 40) begin
            tick();
            t++;
        end
        if (t >= 40) checkVal("t7StepTimeout", stepCount, 4);
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        checkVal("t7RstOutputs", {oByteRdy, oEncEN, oEncData, oEncRst, oCode, oCodeMask,
                                  oCodeVld, oBusy, oDone}, 0);
        expQ.delete();
        tick();
        checkVal("t7StillIdle", oBusy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
